// File: rtl/switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the N-port address-routed switch:
//   - default parameter values for switch_nport
//   - bcast_addr(): the all-ones broadcast address for a given address width
//   - port_idx_t: output port index (wide enough for up to 16 ports)
//   - fwd_cnt_t: 16-bit per-port forward counter
// No ports (package only).
// ---------------------------------------------------------------------------
package switch_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef logic [3:0]  port_idx_t;
  typedef logic [15:0] fwd_cnt_t;

  // All-ones address of the given width, returned in a 32-bit container so
  // callers can size-cast it down to their own address width.
  function automatic logic [31:0] bcast_addr(input int addr_w);
    logic [63:0] ones;
    ones = (64'd1 << addr_w) - 64'd1;
    return ones[31:0];
  endfunction

endpackage

// File: rtl/switch_fifo.sv
// ---------------------------------------------------------------------------
// switch_fifo
// Synchronous FIFO used as one output queue of the switch. The head entry is
// presented combinationally from storage (first-word fall-through).
// Ports:
//   clock        sole clock, rising edge
//   rst          synchronous active-high reset (empties the FIFO)
//   push, wdata  write request and data; ignored while full
//   pop          read request; ignored while empty
//   rdata        head-of-queue data, valid while !empty
//   full, empty  registered occupancy flags (derived from pointer flops)
// ---------------------------------------------------------------------------
module switch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so that equal indices can be told apart
  // as either empty (same lap) or full (writer one lap ahead).
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers and storage; a push and pop in the same cycle
  // advance both pointers so occupancy is unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Pointer flops; reset empties the queue.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; contents are only meaningful
  // between the pointers.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/switch_nport.sv
// ---------------------------------------------------------------------------
// switch_nport
// Single-input, NUM_PORTS-output address-routed switch. The top bits of addr
// select one output FIFO; the all-ones address is copied into every FIFO.
// Each output port is an independent valid/ready stream.
// Ports:
//   clock, rst        clock and synchronous active-high reset
//   vld, addr, data_in, rdy        input stream (accepted on vld && rdy)
//   out_vld, out_addr, out_data    per-port head of queue (packed per port)
//   out_rdy                        per-port sink ready
//   fwd_cnt           per-port saturating push counters (SWITCH_STATS_EN only)
// Optional feature macro: SWITCH_STATS_EN
// ---------------------------------------------------------------------------
module switch_nport
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        vld,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data_in,
  output logic                        rdy,
  output logic [NUM_PORTS-1:0]        out_vld,
  output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  input  logic [NUM_PORTS-1:0]        out_rdy
`ifdef SWITCH_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]     fwd_cnt
`endif
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(bcast_addr(ADDR_W));

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  port_idx_t            dest;
  logic                 is_bcast;
  logic                 accept;

  assign dest     = port_idx_t'(addr[ADDR_W-1 -: PORT_W]);
  assign is_bcast = (addr == BCAST);

  // Ready looks only at the address and the registered full flags, so a pop
  // in the same cycle never makes room for this cycle's push.
  always_comb begin
    rdy = 1'b0;
    if (is_bcast) begin
      rdy = ~|full;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (dest == port_idx_t'(p)) begin
          rdy = !full[p];
        end
      end
    end
  end

  assign accept = vld && rdy;

  // Push vector: the addressed port, or every port for a broadcast.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p] = accept && (is_bcast || (dest == port_idx_t'(p)));
    end
  end

  assign out_vld = ~empty;
  assign pop     = out_vld & out_rdy;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [ADDR_W+DATA_W-1:0] head;

    switch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
      .clock (clock),
      .rst   (rst),
      .push  (push[g]),
      .wdata ({addr, data_in}),
      .pop   (pop[g]),
      .rdata (head),
      .full  (full[g]),
      .empty (empty[g])
    );

    assign out_addr[g*ADDR_W +: ADDR_W] = head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign out_data[g*DATA_W +: DATA_W] = head[DATA_W-1:0];
  end

`ifdef SWITCH_STATS_EN
  fwd_cnt_t cnt_q [NUM_PORTS];
  fwd_cnt_t cnt_d [NUM_PORTS];

  // Per-port push counters that stick at all-ones instead of wrapping.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (push[p] && (cnt_q[p] != 16'hFFFF)) begin
        cnt_d[p] = cnt_q[p] + 16'd1;
      end
    end
  end

  // Counter flops, cleared by reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign fwd_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule
